// File: rtl/mp_add_pkg.sv
// Shared defaults and state encoding for the multi-precision add/subtract sequencer.
package mp_add_pkg;

  localparam int CHUNK_DEF = 16;
  localparam int WORDS_DEF = 4;
  localparam int IDX_W     = (WORDS_DEF > 1) ? $clog2(WORDS_DEF) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/cla_chunk.sv
// CHUNK-bit carry-lookahead adder: 4-bit group generate/propagate combined by a
// second lookahead level. Also exposes the carry into the MSB for overflow.
module cla_chunk #(
  parameter int CHUNK = 16
) (
  input  logic [CHUNK-1:0] a_i,
  input  logic [CHUNK-1:0] b_i,
  input  logic             cin_i,
  output logic [CHUNK-1:0] sum_o,
  output logic             cout_o,
  output logic             cmsb_o
);

  localparam int NG = CHUNK / 4;

  logic [CHUNK-1:0] p_s;
  logic [CHUNK-1:0] g_s;
  logic [CHUNK-1:0] bit_c_s;
  logic [NG-1:0]    grp_p_s;
  logic [NG-1:0]    grp_g_s;
  logic [NG:0]      grp_c_s;
  logic             lk_s;

  assign p_s = a_i ^ b_i;
  assign g_s = a_i & b_i;

  // Group G/P, then each group carry expanded from cin and all lower groups
  always_comb begin
    grp_p_s = '0;
    grp_g_s = '0;
    grp_c_s = '0;
    bit_c_s = '0;
    lk_s    = 1'b0;
    for (int j = 0; j < NG; j++) begin
      grp_p_s[j] = &p_s[4*j +: 4];
      grp_g_s[j] = g_s[4*j+3]
                 | (p_s[4*j+3] & g_s[4*j+2])
                 | (p_s[4*j+3] & p_s[4*j+2] & g_s[4*j+1])
                 | (p_s[4*j+3] & p_s[4*j+2] & p_s[4*j+1] & g_s[4*j]);
    end
    grp_c_s[0] = cin_i;
    for (int j = 0; j < NG; j++) begin
      lk_s = cin_i;
      for (int k = 0; k <= j; k++) begin
        lk_s = grp_g_s[k] | (grp_p_s[k] & lk_s);
      end
      grp_c_s[j+1] = lk_s;
    end
    for (int j = 0; j < NG; j++) begin
      bit_c_s[4*j]   = grp_c_s[j];
      bit_c_s[4*j+1] = g_s[4*j] | (p_s[4*j] & grp_c_s[j]);
      bit_c_s[4*j+2] = g_s[4*j+1] | (p_s[4*j+1] & g_s[4*j])
                     | (p_s[4*j+1] & p_s[4*j] & grp_c_s[j]);
      bit_c_s[4*j+3] = g_s[4*j+2] | (p_s[4*j+2] & g_s[4*j+1])
                     | (p_s[4*j+2] & p_s[4*j+1] & g_s[4*j])
                     | (p_s[4*j+2] & p_s[4*j+1] & p_s[4*j] & grp_c_s[j]);
    end
  end

  assign sum_o  = p_s ^ bit_c_s;
  assign cout_o = grp_c_s[NG];
  assign cmsb_o = bit_c_s[CHUNK-1];

endmodule

// File: rtl/mp_add_seq.sv
// Multi-precision add/subtract: one CHUNK-bit CLA reused WORDS times, LS chunk
// first, with the chunk carry registered between cycles.
module mp_add_seq
  import mp_add_pkg::*;
#(
  parameter int CHUNK = CHUNK_DEF,
  parameter int WORDS = WORDS_DEF
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   sub,
  input  logic [CHUNK*WORDS-1:0] a,
  input  logic [CHUNK*WORDS-1:0] b,
  output logic                   ready,
  output logic                   busy,
  output logic                   done,
  output logic [CHUNK*WORDS-1:0] sum,
  output logic                   cout,
  output logic                   ovf
);

  localparam int N  = CHUNK * WORDS;
  localparam int IW = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(WORDS - 1);

  state_e         state_q, state_d;
  logic [N-1:0]   a_q, a_d;
  logic [N-1:0]   b_q, b_d;
  logic [N-1:0]   sum_q, sum_d;
  logic           carry_q, carry_d;
  logic [IW-1:0]  idx_q, idx_d;
  logic           cout_q, cout_d;
  logic           ovf_q, ovf_d;
  logic           ready_q, busy_q, done_q;

  logic [CHUNK-1:0] add_a_s, add_b_s, add_sum_s;
  logic             add_cout_s, add_cmsb_s;

  assign add_a_s = a_q[idx_q*CHUNK +: CHUNK];
  assign add_b_s = b_q[idx_q*CHUNK +: CHUNK];

  cla_chunk #(.CHUNK(CHUNK)) u_cla (
    .a_i    (add_a_s),
    .b_i    (add_b_s),
    .cin_i  (carry_q),
    .sum_o  (add_sum_s),
    .cout_o (add_cout_s),
    .cmsb_o (add_cmsb_s)
  );

  // Next-state and datapath update
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    idx_d   = idx_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          a_d     = a;
          b_d     = sub ? ~b : b;
          carry_d = sub;
          idx_d   = {IW{1'b0}};
          state_d = RUN;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        sum_d[idx_q*CHUNK +: CHUNK] = add_sum_s;
        carry_d = add_cout_s;
        idx_d   = idx_q + IW'(1);
        if (idx_q == LAST_IDX) begin
          cout_d  = add_cout_s;
          // Carry into MSB differing from carry out is signed overflow
          ovf_d   = add_cout_s ^ add_cmsb_s;
          state_d = DONE;
        end else begin
          state_d = RUN;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, datapath and registered handshake outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= {N{1'b0}};
      b_q     <= {N{1'b0}};
      sum_q   <= {N{1'b0}};
      carry_q <= 1'b0;
      idx_q   <= {IW{1'b0}};
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      ready_q <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      idx_q   <= idx_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
      ready_q <= (state_d == IDLE);
      busy_q  <= (state_d == RUN);
      done_q  <= (state_d == DONE);
    end
  end

  assign ready = ready_q;
  assign busy  = busy_q;
  assign done  = done_q;
  assign sum   = sum_q;
  assign cout  = cout_q;
  assign ovf   = ovf_q;

endmodule

// File: tb/tb_mp_add_seq.sv
// Directed and random checks of mp_add_seq against hand-computed values and an N-bit model.
module tb_mp_add_seq;

  localparam int N = 64;

  logic         clk = 1'b0;
  logic         rst, start, sub;
  logic [N-1:0] a, b;
  logic         ready, busy, done, cout, ovf;
  logic [N-1:0] sum;

  int n_cmp = 0;
  int n_err = 0;

  mp_add_seq dut (
    .clk(clk), .rst(rst), .start(start), .sub(sub), .a(a), .b(b),
    .ready(ready), .busy(busy), .done(done), .sum(sum), .cout(cout), .ovf(ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [N-1:0] obs, input logic [N-1:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_op(input string tag, input logic [N-1:0] ia, input logic [N-1:0] ib,
                        input logic isub, input logic [N-1:0] es, input logic ec,
                        input logic eo, input int elat);
    int lat;
    chk({tag, ".ready"}, 64'(ready), 64'd1);
    a = ia; b = ib; sub = isub; start = 1'b1;
    tick();
    start = 1'b0;
    a = {$urandom, $urandom};
    b = {$urandom, $urandom};
    sub = ~isub;
    lat = 1;
    while (!done && lat < 20) begin
      tick();
      lat++;
    end
    chk({tag, ".done"}, 64'(done), 64'd1);
    if (elat > 0) chk({tag, ".lat"}, 64'(lat), 64'(elat));
    chk({tag, ".sum"}, sum, es);
    chk({tag, ".cout"}, 64'(cout), 64'(ec));
    chk({tag, ".ovf"}, 64'(ovf), 64'(eo));
    tick();
    chk({tag, ".hold_sum"}, sum, es);
    chk({tag, ".hold_flags"}, {62'd0, cout, ovf}, {62'd0, ec, eo});
    chk({tag, ".idle"}, {61'd0, ready, busy, done}, {61'd0, 1'b1, 1'b0, 1'b0});
  endtask

  initial begin
    logic [N-1:0] ra, rb, bb, es;
    logic [N:0]   full;
    logic         rs, eo;
    int           dcount;

    rst = 1'b1; start = 1'b0; sub = 1'b0; a = 64'd0; b = 64'd0;
    repeat (3) tick();
    rst = 1'b0;
    chk("reset.hs", {61'd0, ready, busy, done}, {61'd0, 1'b1, 1'b0, 1'b0});
    chk("reset.sum", sum, 64'd0);
    chk("reset.flags", {62'd0, cout, ovf}, 64'd0);

    run_op("inc16", 64'h0000_0000_0000_FFFF, 64'd1, 1'b0, 64'h0000_0000_0001_0000, 1'b0, 1'b0, 5);
    run_op("wrap", 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 64'd0, 1'b1, 1'b0, 5);
    run_op("povf", 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 64'h8000_0000_0000_0000, 1'b0, 1'b1, 5);
    run_op("s5m7", 64'd5, 64'd7, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0, 5);
    run_op("s7m5", 64'd7, 64'd5, 1'b1, 64'd2, 1'b1, 1'b0, 5);
    run_op("novf", 64'h8000_0000_0000_0000, 64'd1, 1'b1, 64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 1'b1, 5);

    // start held high with changing operands through RUN and DONE
    a = 64'd1; b = 64'd2; sub = 1'b0; start = 1'b1;
    tick();
    dcount = 0;
    for (int i = 0; i < 5; i++) begin
      chk("spam.ready", 64'(ready), 64'd0);
      chk("spam.busy", 64'(busy), 64'(i < 4));
      if (done) dcount++;
      a = {$urandom, $urandom}; b = {$urandom, $urandom}; sub = 1'($urandom);
      tick();
    end
    start = 1'b0;
    chk("spam.sum", sum, 64'd3);
    chk("spam.ndone", 64'(dcount), 64'd1);
    chk("spam.idle", {61'd0, ready, busy, done}, {61'd0, 1'b1, 1'b0, 1'b0});

    // reset on the second RUN cycle aborts with no done
    a = 64'hFFFF_FFFF_FFFF_FFFF; b = 64'd1; sub = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("abort.hs", {61'd0, ready, busy, done}, {61'd0, 1'b1, 1'b0, 1'b0});
    chk("abort.sum", sum, 64'd0);
    chk("abort.flags", {62'd0, cout, ovf}, 64'd0);
    dcount = 0;
    for (int i = 0; i < 8; i++) begin
      if (done) dcount++;
      tick();
    end
    chk("abort.nodone", 64'(dcount), 64'd0);
    run_op("after_abort", 64'd7, 64'd5, 1'b1, 64'd2, 1'b1, 1'b0, 5);

    for (int i = 0; i < 1000; i++) begin
      ra = {$urandom, $urandom};
      rb = (i % 8 == 0) ? ~ra : {$urandom, $urandom};
      rs = 1'($urandom_range(0, 1));
      bb = rs ? ~rb : rb;
      full = {1'b0, ra} + {1'b0, bb} + 65'(rs);
      es = full[N-1:0];
      eo = (ra[N-1] == bb[N-1]) && (es[N-1] != ra[N-1]);
      run_op($sformatf("rnd%0d", i), ra, rb, rs, es, full[N], eo, 5);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
